video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Transmit-side raster timing generator for the median-filter output path.
- Free-runs horizontal and vertical counters and emits hsync, vsync, de and active-pixel coordinates.
- Its sync outputs are the same pulse format addr_ctrl consumes on the receive side, so filtered pixels can be re-serialised to the display or looped back into the input path for test.

Parameters:
- ADDR_W, 11: width of the x/y coordinate outputs.
- H_ACTIVE, 1280: active pixels per line.
- H_FP, 110: horizontal front porch, in clocks.
- H_SYNC, 40: hsync pulse width, in clocks.
- H_BP, 220: horizontal back porch, in clocks.
- V_ACTIVE, 720: active lines per frame.
- V_FP, 5: vertical front porch, in lines.
- V_SYNC, 5: vsync width, in lines.
- V_BP, 20: vertical back porch, in lines.
- HS_POL, 1: asserted level of hsync.
- VS_POL, 1: asserted level of vsync.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 freezes timing.
- hsync  out  1  horizontal sync, asserted level HS_POL.
- vsync  out  1  vertical sync, asserted level VS_POL.
- de  out  1  active-video flag.
- x  out  ADDR_W  pixel index in line, valid when de.
- y  out  ADDR_W  line index in frame, valid when de.
- line_start  out  1  one-cycle pulse on first active pixel of each active line.
- frame_start  out  1  one-cycle pulse on pixel (0,0).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: hsync=~HS_POL, vsync=~VS_POL, de=0, x=0, y=0, line_start=0, frame_start=0. Counters h_cnt=0, v_cnt=0. Both FSMs go to the ACT state.
- Counters:
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt counts 0..V_TOTAL-1 and increments only when h_cnt wraps.
  - Counter width is ADDR_W+1.
  - Elaboration error if H_TOTAL or V_TOTAL does not fit, or if any timing parameter is 0.
- Horizontal FSM, states ACT -> FP -> SYNC -> BP -> ACT:
  - Each state lasts exactly its parameter count of en-qualified clocks.
  - BP->ACT coincides with the h_cnt wrap.
- Vertical FSM, same four states in lines: advances only on the h_cnt wrap. Vertical state therefore changes together with line start, not with the hsync edge.
- Output latency: registered, one cycle.
  - Outputs at edge n+1 reflect counter/FSM state at edge n.
  - de = (hstate==ACT && vstate==ACT).
  - hsync asserted iff hstate==SYNC.
  - vsync asserted iff vstate==SYNC, for whole lines (h_cnt 0..H_TOTAL-1).
- Coordinates:
  - x = h_cnt and y = v_cnt while de=1.
  - x=0 and y=0 while de=0; they never show porch counts.
- Strobes:
  - line_start = de && h_cnt==0.
  - frame_start = de && h_cnt==0 && v_cnt==0.
- en=0:
  - Counters and FSMs hold.
  - Next cycle de, line_start and frame_start are forced 0; hsync, vsync, x and y hold.
  - On en=1 timing resumes exactly where it stopped, with no skipped or repeated count.
- Wrap: at h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1, both counters return to 0 on the same edge. The next output cycle is frame_start.
- Reset mid-frame: rst has priority over en. All state returns to reset values on that edge. The first en-qualified edge after release outputs pixel (0,0) with frame_start=1; no partial frame completes.
- rst and en never combine to produce sync pulses shorter than the parameter value, except when truncated by reset.

Decomposition:
- Shared package video_timing_pkg holds:
  - the phase enum (ACT, FP, SYNC, BP);
  - a function computing totals;
  - the 720p default constants, shared with addr_ctrl-side benches.
- One sub-module, timing_axis. It holds one counter plus its phase FSM, parameterised by ACTIVE/FP/SYNC/BP and a step input.
  - Instantiate it twice: horizontal with step=en, vertical with step=en && h_wrap.
  - It exports phase and wrap.

Test Plan:
Benches use H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=2 (H_TOTAL=8) and V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6). Polarity is 1 unless stated.
- Reset release, en=1:
  - Edges 1-4: de=1, x=0..3, y=0; edge 1 has frame_start=1 and line_start=1.
  - Edge 6: hsync=1 for exactly one cycle.
  - Edge 9: de=1, y=1, line_start=1.
- Full frame:
  - Exactly 12 de cycles per 48 clocks.
  - vsync=1 for exactly 8 consecutive clocks, starting at clock 33 (line 4).
  - frame_start recurs at edge 49.
- en gating: drop en for 3 cycles at x=2.
  - de=0 for those 3 cycles; x holds at 2.
  - Resume emits x=3 next, with no x value repeated or skipped.
- Reset mid-frame: assert rst for 1 cycle at v_cnt=4.
  - Following cycle: all outputs at reset values.
  - First cycle after release: frame_start=1, x=0, y=0.
- Polarity: HS_POL=0, VS_POL=0.
  - hsync idles 1, pulses 0 for one cycle per line.
  - vsync idles 1, 0 for 8 clocks.
  - de timing is unchanged.
- 720p defaults, 2 frames: 1650 clocks per line, 750 lines per frame, 921600 de cycles per frame.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared raster-timing types and defaults for the video_timing_gen / addr_ctrl path.
// Phase enum, total-length helper and the 720p constants.
package video_timing_pkg;

  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_t;

  localparam int unsigned DEF_ADDR_W   = 11;
  localparam int unsigned DEF_H_ACTIVE = 1280;
  localparam int unsigned DEF_H_FP     = 110;
  localparam int unsigned DEF_H_SYNC   = 40;
  localparam int unsigned DEF_H_BP     = 220;
  localparam int unsigned DEF_V_ACTIVE = 720;
  localparam int unsigned DEF_V_FP     = 5;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BP     = 20;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_timing_axis.sv
// One raster axis: a free-running counter plus its ACT/FP/SYNC/BP phase FSM.
// Latency: phase and count update on the step edge; step=0 holds everything.
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 4,
  parameter int unsigned FP     = 1,
  parameter int unsigned SYNC   = 1,
  parameter int unsigned BP     = 2,
  parameter int unsigned CNT_W  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output phase_t           phase,
  output logic             wrap
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] END_ACT  = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] END_FP   = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] END_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] END_BP   = CNT_W'(TOTAL - 1);

  phase_t phase_nxt;

  assign wrap = step && (cnt == END_BP);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= PH_ACT;
    end else if (step) begin
      cnt   <= wrap ? '0 : cnt + 1'b1;
      phase <= phase_nxt;
    end
  end

  // Each phase ends on the last count of its interval; BP ends exactly on the wrap.
  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_ACT:  if (cnt == END_ACT)  phase_nxt = PH_FP;
      PH_FP:   if (cnt == END_FP)   phase_nxt = PH_SYNC;
      PH_SYNC: if (cnt == END_SYNC) phase_nxt = PH_BP;
      PH_BP:   if (cnt == END_BP)   phase_nxt = PH_ACT;
      default: phase_nxt = PH_ACT;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Transmit-side raster timing: hsync/vsync/de, coordinates and line/frame strobes.
// Latency: registered, one cycle; en=0 freezes timing and masks de and strobes.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [ADDR_W-1:0] x,
  output logic [ADDR_W-1:0] y,
  output logic              line_start,
  output logic              frame_start
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_param
    $error("video_timing_gen: timing parameters must be non-zero");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_total_fit
    $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit the counter width");
  end
  if (H_ACTIVE > (1 << ADDR_W) || V_ACTIVE > (1 << ADDR_W)) begin : g_coord_fit
    $error("video_timing_gen: active area does not fit ADDR_W coordinates");
  end

  logic [CNT_W-1:0] h_cnt, v_cnt;
  phase_t           h_phase, v_phase;
  logic             h_wrap, v_wrap;
  logic             de_nxt;
  logic             unused_bits;

  timing_axis #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)) u_h_axis (
    .clk(clk), .rst(rst), .step(en), .cnt(h_cnt), .phase(h_phase), .wrap(h_wrap)
  );

  // h_wrap already carries en, so the vertical axis steps once per completed line.
  timing_axis #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)) u_v_axis (
    .clk(clk), .rst(rst), .step(h_wrap), .cnt(v_cnt), .phase(v_phase), .wrap(v_wrap)
  );

  assign de_nxt      = (h_phase == PH_ACT) && (v_phase == PH_ACT);
  assign unused_bits = &{1'b0, v_wrap, h_cnt[ADDR_W], v_cnt[ADDR_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hsync       <= (h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
      vsync       <= (v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
      de          <= de_nxt;
      x           <= de_nxt ? h_cnt[ADDR_W-1:0] : '0;
      y           <= de_nxt ? v_cnt[ADDR_W-1:0] : '0;
      line_start  <= de_nxt && (h_cnt == '0);
      frame_start <= de_nxt && (h_cnt == '0) && (v_cnt == '0);
    end else begin
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small raster, positive and negative polarity instances,
// checked every cycle against a position-based raster model.
module tb_video_timing_gen;

  localparam int HA = 4, HF = 1, HS = 1, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        hsync, vsync, de, line_start, frame_start;
  logic [10:0] x, y;
  logic        n_hsync, n_vsync, n_de, n_line_start, n_frame_start;
  logic [10:0] n_x, n_y;

  always #5 clk = ~clk;

  video_timing_gen #(
    .ADDR_W(11), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
  );

  video_timing_gen #(
    .ADDR_W(11), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .clk(clk), .rst(rst), .en(en), .hsync(n_hsync), .vsync(n_vsync), .de(n_de),
    .x(n_x), .y(n_y), .line_start(n_line_start), .frame_start(n_frame_start)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: raster position (mh, mv) and the expected registered outputs.
  int mh = 0, mv = 0;
  int e_hs = 0, e_vs = 0, e_de = 0, e_x = 0, e_y = 0, e_ls = 0, e_fs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic step_cycle(input logic r, input logic e);
    @(negedge clk);
    rst = r;
    en  = e;
    if (r) begin
      mh = 0; mv = 0;
      e_hs = 0; e_vs = 0; e_de = 0; e_x = 0; e_y = 0; e_ls = 0; e_fs = 0;
    end else if (e) begin
      e_de = (mh < HA && mv < VA) ? 1 : 0;
      e_hs = (mh >= HA + HF && mh < HA + HF + HS) ? 1 : 0;
      e_vs = (mv >= VA + VF && mv < VA + VF + VS) ? 1 : 0;
      e_x  = e_de ? mh : 0;
      e_y  = e_de ? mv : 0;
      e_ls = (e_de && mh == 0) ? 1 : 0;
      e_fs = (e_ls && mv == 0) ? 1 : 0;
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0;
        mv = (mv + 1) % VT;
      end
    end else begin
      e_de = 0; e_ls = 0; e_fs = 0;
    end
    @(posedge clk);
    #1;
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("de", 32'(de), 32'(e_de));
    check("x", 32'(x), 32'(e_x));
    check("y", 32'(y), 32'(e_y));
    check("line_start", 32'(line_start), 32'(e_ls));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("n_hsync", 32'(n_hsync), 32'(1 - e_hs));
    check("n_vsync", 32'(n_vsync), 32'(1 - e_vs));
    check("n_de", 32'(n_de), 32'(e_de));
    check("n_x", 32'(n_x), 32'(e_x));
    check("n_line_start", 32'(n_line_start), 32'(e_ls));
  endtask

  initial begin
    int de_cnt, vs_first, vs_len, fs_second, guard;

    // Reset edge: outputs at reset values.
    step_cycle(1'b1, 1'b0);
    step_cycle(1'b1, 1'b1);

    // Two free-running frames with frame-level statistics.
    de_cnt = 0; vs_first = 0; vs_len = 0; fs_second = 0;
    for (int k = 1; k <= 2 * HT * VT; k++) begin
      step_cycle(1'b0, 1'b1);
      if (k <= HT * VT) begin
        if (de) de_cnt++;
        if (vsync) begin
          vs_len++;
          if (vs_first == 0) vs_first = k;
        end
      end
      if (k > 1 && frame_start && fs_second == 0) fs_second = k;
    end
    check("de_per_frame", 32'(de_cnt), 32'd12);
    check("vsync_start", 32'(vs_first), 32'd33);
    check("vsync_len", 32'(vs_len), 32'd8);
    check("frame_repeat", 32'(fs_second), 32'd49);

    // en gating: pixels 0,1,2 then three frozen cycles, then pixel 3.
    for (int k = 0; k < 3; k++) step_cycle(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step_cycle(1'b0, 1'b0);
      check("gate_x_hold", 32'(x), 32'd2);
    end
    step_cycle(1'b0, 1'b1);
    check("gate_resume_x", 32'(x), 32'd3);

    // Reset mid-frame on line 4.
    guard = 0;
    while (mv != 4 && guard < 2 * HT * VT) begin
      step_cycle(1'b0, 1'b1);
      guard++;
    end
    check("reach_line4", 32'(mv), 32'd4);
    step_cycle(1'b0, 1'b1);
    step_cycle(1'b1, 1'b1);
    step_cycle(1'b0, 1'b1);
    check("post_rst_fs", 32'(frame_start), 32'd1);

    // Randomised en/rst traffic.
    for (int k = 0; k < 1500; k++) begin
      step_cycle(($urandom_range(99) == 0), ($urandom_range(9) < 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
